// File: rtl/dsram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dsram_pkg
// Purpose  : Shared definitions for the data SRAM responder.
//            - MMIO register offsets inside the 64 KiB window
//            - decode-target and return-path FSM state encodings
//            - byte-lane merge helper used by every writable register
// Revision : 1.0  initial release
// ============================================================================
package dsram_pkg;

    localparam logic [15:0] LED_OFS     = 16'h0000;
    localparam logic [15:0] TIMER_OFS   = 16'h0004;
    localparam logic [15:0] SCRATCH_OFS = 16'h0008;

    typedef enum logic [0:0] {
        RAM  = 1'b0,
        MMIO = 1'b1
    } target_e;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RESP = 1'b1
    } rsp_state_e;

    // Replace the byte lanes selected by wen with the matching lanes of new_word.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  wen);
        logic [31:0] result;
        result = old_word;
        for (int i = 0; i < 4; i++) begin
            if (wen[i]) result[8*i +: 8] = new_word[8*i +: 8];
        end
        return result;
    endfunction

endpackage : dsram_pkg
`default_nettype wire

// File: rtl/sram_bank.sv
`default_nettype none
// ============================================================================
// Module   : sram_bank
// Purpose  : Single-port synchronous RAM with byte-lane writes and
//            write-first read behaviour (a write returns the merged word).
// Ports    : clk    in  1        clock
//            en     in  1        access enable
//            we     in  DW/8     byte-lane write enables (0 = read)
//            addr   in  AW       word address
//            wdata  in  DW       write data
//            rdata  out DW       registered read data (updated only on en)
// Params   : AW (address width), DW (data width, multiple of 8)
// Revision : 1.0  initial release
// ============================================================================
module sram_bank #(
    parameter int AW = 14,
    parameter int DW = 32
) (
    input  logic              clk,
    input  logic              en,
    input  logic [DW/8-1:0]   we,
    input  logic [AW-1:0]     addr,
    input  logic [DW-1:0]     wdata,
    output logic [DW-1:0]     rdata
);

    logic [DW-1:0] r_mem [0:(2**AW)-1];
    logic [DW-1:0] r_q;
    logic [DW-1:0] w_merged;

    // Post-write word: serves both as the stored value and as the write-first
    // read result. With we=0 it is simply the current contents.
    always_comb begin
        w_merged = r_mem[addr];
        for (int i = 0; i < DW/8; i++) begin
            if (we[i]) w_merged[8*i +: 8] = wdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            if (|we) r_mem[addr] <= w_merged;
            r_q <= w_merged;
        end
    end

    assign rdata = r_q;

endmodule : sram_bank
`default_nettype wire

// File: rtl/data_sram_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_sram_responder
// Purpose  : Memory-side responder for the CPU data_sram_* port. Requests
//            are decoded to a word-addressed RAM bank or a small MMIO window
//            (LED, TIMER, SCRATCH); read data returns exactly one cycle later.
// Ports    : clk              in  1      clock
//            reset            in  1      synchronous active-high reset
//            data_sram_en     in  1      request valid
//            data_sram_wen    in  4      byte-lane write enables, 0 = read
//            data_sram_addr   in  32     byte address (bits [1:0] ignored)
//            data_sram_wdata  in  32     write data
//            data_sram_rdata  out 32     response data, one cycle after request
//            led              out LED_W  LED register contents
// Config   : DSRAM_MMIO_TIMER_EN  when defined, the free-running TIMER register
//            exists at offset 0x0004; otherwise that offset reads 0.
// Revision : 1.0  initial release
// ============================================================================
module data_sram_responder #(
    parameter int          RAM_AW    = 14,
    parameter logic [31:0] MMIO_BASE = 32'h1FAF_0000,
    parameter int          LED_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              data_sram_en,
    input  logic [3:0]        data_sram_wen,
    input  logic [31:0]       data_sram_addr,
    input  logic [31:0]       data_sram_wdata,
    output logic [31:0]       data_sram_rdata,
    output logic [LED_W-1:0]  led
);

    import dsram_pkg::*;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic        w_req;
    logic        w_wr;
    logic        w_is_mmio;
    target_e     w_target;
    logic [15:0] w_ofs;

    // A request coinciding with reset is discarded entirely.
    assign w_req     = data_sram_en & ~reset;
    assign w_wr      = |data_sram_wen;
    assign w_is_mmio = (data_sram_addr[31:16] == MMIO_BASE[31:16]);
    assign w_target  = w_is_mmio ? MMIO : RAM;
    assign w_ofs     = data_sram_addr[15:0] & 16'hFFFC;

    // ------------------------------------------------------------------
    // RAM bank (upper address bits beyond RAM_AW+1 alias)
    // ------------------------------------------------------------------
    logic [31:0] w_ram_q;

    sram_bank #(
        .AW (RAM_AW),
        .DW (32)
    ) u_bank (
        .clk   (clk),
        .en    (w_req & ~w_is_mmio),
        .we    (data_sram_wen),
        .addr  (data_sram_addr[RAM_AW+1:2]),
        .wdata (data_sram_wdata),
        .rdata (w_ram_q)
    );

    // ------------------------------------------------------------------
    // MMIO registers
    // ------------------------------------------------------------------
    logic [LED_W-1:0] r_led;
    logic [31:0]      r_scratch;
    logic [31:0]      r_mmio_q;
    logic [31:0]      w_led_post;
    logic [31:0]      w_scratch_post;
    logic [31:0]      w_timer_cur;
    logic [31:0]      w_timer_post;
    logic [31:0]      w_mmio_rsp;

    // With wen=0 the "post" values equal the current contents, so they
    // double as read values.
    assign w_led_post     = merge_lanes(32'(r_led), data_sram_wdata, data_sram_wen);
    assign w_scratch_post = merge_lanes(r_scratch, data_sram_wdata, data_sram_wen);

`ifdef DSRAM_MMIO_TIMER_EN
    logic [31:0] r_timer;
    logic [31:0] w_timer_inc;
    logic        w_timer_wr;

    assign w_timer_inc  = r_timer + 32'd1;
    // Unwritten lanes keep counting; written lanes take the new data.
    assign w_timer_post = merge_lanes(w_timer_inc, data_sram_wdata, data_sram_wen);
    assign w_timer_wr   = w_req & w_is_mmio & w_wr & (w_ofs == TIMER_OFS);
    assign w_timer_cur  = r_timer;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_timer <= '0;
        end else if (w_timer_wr) begin
            r_timer <= w_timer_post;
        end else begin
            r_timer <= w_timer_inc;
        end
    end
`else
    assign w_timer_cur  = '0;
    assign w_timer_post = '0;
`endif

    // Response word for an MMIO access: reads return the pre-edge value,
    // writes return the word as it stands after the edge.
    always_comb begin
        w_mmio_rsp = '0;
        case (w_ofs)
            LED_OFS:     w_mmio_rsp = 32'(w_led_post[LED_W-1:0]);
            TIMER_OFS:   w_mmio_rsp = w_wr ? w_timer_post : w_timer_cur;
            SCRATCH_OFS: w_mmio_rsp = w_scratch_post;
            default:     w_mmio_rsp = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_led     <= '0;
            r_scratch <= '0;
            r_mmio_q  <= '0;
        end else if (w_req && w_is_mmio) begin
            r_mmio_q <= w_mmio_rsp;
            if (w_ofs == LED_OFS)     r_led     <= w_led_post[LED_W-1:0];
            if (w_ofs == SCRATCH_OFS) r_scratch <= w_scratch_post;
        end
    end

    // ------------------------------------------------------------------
    // Return path: target select, response FSM and hold register
    // ------------------------------------------------------------------
    target_e     r_rsp_sel;
    rsp_state_e  r_state;
    rsp_state_e  w_state_next;
    logic [31:0] w_ret;
    logic [31:0] r_hold;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_sel <= RAM;
        end else if (w_req) begin
            r_rsp_sel <= w_target;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (data_sram_en)  w_state_next = RESP;
            RESP:    if (!data_sram_en) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    assign w_ret = (r_rsp_sel == MMIO) ? r_mmio_q : w_ram_q;

    // The hold register remembers the last presented response so rdata
    // stays put while no response is owed, independent of the sources.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold <= '0;
        end else if (r_state == RESP) begin
            r_hold <= w_ret;
        end
    end

    assign data_sram_rdata = (r_state == RESP) ? w_ret : r_hold;
    assign led             = r_led;

endmodule : data_sram_responder
`default_nettype wire
